// File: rtl/latch_monitor.sv
// Clocked checker for a transparent D-latch with active-low reset (d/en/rstn -> q).
// Optional build macro LATCH_MON_HALT_EN: stop checking after the first violation.
`timescale 1ns/1ps

module latch_monitor #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             mon_d,
    input  logic             mon_en,
    input  logic             mon_rstn,
    input  logic             mon_q,
    output logic             busy,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
`ifdef LATCH_MON_HALT_EN
    localparam logic [2:0] ST_HALT   = 3'd4;
`endif

    // Counter reload value; SETTLE_CYC=0 bypasses SETTLE entirely.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ref_q_q, ref_q_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

    logic             smp_d_q, smp_en_q, smp_rstn_q, smp_q_q;
    logic [2:0]       prv_trip_q;
    logic             chg;
    logic             viol;
    logic [1:0]       viol_code;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign chg = ({smp_d_q, smp_en_q, smp_rstn_q} != prv_trip_q);

    // Latch rules in priority order: reset dominates, then transparency, then hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        viol      = 1'b0;
        viol_code = 2'd0;
        if (!smp_rstn_q) begin
            viol      = smp_q_q;
            viol_code = 2'd1;
        end else if (smp_en_q) begin
            viol      = smp_q_q ^ smp_d_q;
            viol_code = 2'd2;
        end else begin
            viol      = smp_q_q ^ ref_q_q;
            viol_code = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_q_d     = ref_q_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (chk_en) begin
                    state_d = ST_ARMED;
                    ref_q_d = smp_q_q;
                end
            end
            ST_ARMED: begin
                if (chg) begin
                    if (SETTLE_CYC == 0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (chg) begin
                    cnt_d = SETTLE_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                chk_cnt_d = sat_inc(chk_cnt_q);
                ref_q_d   = smp_q_q;
                if (viol) begin
                    err_valid_d = 1'b1;
                    err_code_d  = viol_code;
                    err_cnt_d   = sat_inc(err_cnt_q);
                end
                if (!chg) begin
                    state_d = ST_ARMED;
                end else if (SETTLE_CYC == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
`ifdef LATCH_MON_HALT_EN
                if (viol) begin
                    state_d = ST_HALT;
                end
`endif
            end
`ifdef LATCH_MON_HALT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disabling wins over every transition, but a CHECK still commits above.
        if (!chk_en) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
            smp_d_q     <= 1'b0;
            smp_en_q    <= 1'b0;
            smp_rstn_q  <= 1'b0;
            smp_q_q     <= 1'b0;
            prv_trip_q  <= 3'd0;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            ref_q_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
        end else begin
            smp_d_q     <= mon_d;
            smp_en_q    <= mon_en;
            smp_rstn_q  <= mon_rstn;
            smp_q_q     <= mon_q;
            prv_trip_q  <= {smp_d_q, smp_en_q, smp_rstn_q};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q_q     <= ref_q_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
        end
    end

    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign chk_cnt   = chk_cnt_q;

endmodule

// File: tb/tb_latch_monitor.sv
// Self-checking bench for latch_monitor: event-timestamp reference model plus directed latch scenarios.
`timescale 1ns/1ps

module tb_latch_monitor;

    localparam int unsigned SETTLE_CYC = 1;
    localparam int unsigned CNT_W      = 8;
    localparam int          MAXC       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             chk_en;
    logic             mon_d, mon_en, mon_rstn, mon_q;
    logic             busy, err_valid;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] err_cnt, chk_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ev_count = 0;
    bit cmp_on   = 1'b0;

    latch_monitor #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .chk_en    (chk_en),
        .mon_d     (mon_d),
        .mon_en    (mon_en),
        .mon_rstn  (mon_rstn),
        .mon_q     (mon_q),
        .busy      (busy),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_cnt   (err_cnt),
        .chk_cnt   (chk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a check is due SETTLE_CYC+1 edges after the most recent
    // edge at which the sampled input triple was seen to change.
    int  m_cyc = 0;
    int  m_last = 0;
    bit  m_en = 0, m_pend = 0, m_halt = 0, m_ev = 0;
    bit  m_chg, m_bad;
    bit  [2:0] m_s = 0, m_ps = 0;   // {d, en, rstn}
    bit  m_sq = 0, m_prevq = 0;
    bit  [1:0] m_code = 0, m_newcode;
    int  m_err = 0, m_chk = 0;

    always @(posedge clk) begin
        m_cyc++;
        m_ev = 1'b0;
        if (rst) begin
            m_en = 0; m_pend = 0; m_halt = 0;
            m_code = 0; m_err = 0; m_chk = 0; m_prevq = 0;
            m_s = 0; m_ps = 0; m_sq = 0;
        end else begin
            m_chg = (m_s != m_ps);
            if (!m_en) begin
                if (chk_en) begin
                    m_en = 1; m_prevq = m_sq; m_pend = 0;
                end
            end else begin
                if (m_pend && (m_cyc == m_last + int'(SETTLE_CYC) + 1)) begin
                    m_pend = 0;
                    if (m_s[0] == 1'b0) begin
                        m_bad = (m_sq != 1'b0); m_newcode = 2'd1;
                    end else if (m_s[1]) begin
                        m_bad = (m_sq != m_s[2]); m_newcode = 2'd2;
                    end else begin
                        m_bad = (m_sq != m_prevq); m_newcode = 2'd3;
                    end
                    if (m_chk < MAXC) m_chk++;
                    if (m_bad) begin
                        m_ev = 1; m_code = m_newcode;
                        if (m_err < MAXC) m_err++;
`ifdef LATCH_MON_HALT_EN
                        m_halt = 1;
`endif
                    end
                    m_prevq = m_sq;
                end
                if (!chk_en) begin
                    m_en = 0; m_pend = 0; m_halt = 0;
                end else if (m_chg && !m_halt) begin
                    m_pend = 1; m_last = m_cyc;
                end
            end
            m_ps = m_s;
            m_s  = {mon_d, mon_en, mon_rstn};
            m_sq = mon_q;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("busy",      busy,      m_en && m_pend);
            check("err_valid", err_valid, m_ev);
            check("err_code",  err_code,  m_code);
            check("err_cnt",   err_cnt,   m_err);
            check("chk_cnt",   chk_cnt,   m_chk);
            if (err_valid === 1'b1) ev_count++;
        end
    end

    task automatic apply(input logic d, input logic en, input logic rn, input logic q, input int cycles);
        mon_d = d; mon_en = en; mon_rstn = rn; mon_q = q;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_err(input string name, input int budget);
        bit found = 1'b0;
        int n = 0;
        while (!found && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (err_valid === 1'b1) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_err_code"},  err_code,  0);
        check({tag, "_err_cnt"},   err_cnt,   0);
        check({tag, "_chk_cnt"},   chk_cnt,   0);
    endtask

    initial begin
        rst = 1'b1; chk_en = 1'b0;
        mon_d = 0; mon_en = 0; mon_rstn = 0; mon_q = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 1'b1;
        check_zero("reset");
        rst = 1'b0;

        // Latch held in reset, q=0: d toggles give clean checks only.
        chk_en = 1'b1;
        apply(0, 0, 0, 0, 3);
        apply(1, 0, 0, 0, 6);
        apply(0, 0, 0, 0, 6);
        apply(1, 0, 0, 0, 6);
        check("t1_chk_cnt", chk_cnt, 3);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_no_pulse", ev_count, 0);
        check("t1_model_chk", m_chk, 3);

        // Transparent latch, q follows d one cycle late inside the settle window.
        apply(0, 1, 1, 0, 6);
        apply(1, 1, 1, 0, 1);
        apply(1, 1, 1, 1, 6);
        check("t2_chk_cnt", chk_cnt, 5);
        check("t2_err_cnt", err_cnt, 0);

        // Transparent latch, q stuck at 0 while d=1.
        apply(0, 1, 1, 0, 6);
        apply(1, 1, 1, 0, 0);
        wait_err("t3_err_pulse", 10);
        check("t3_err_code", err_code, 2);
        check("t3_err_cnt",  err_cnt,  1);
        check("t3_chk_cnt",  chk_cnt,  7);
        check("t3_model_err", m_err, 1);
        apply(1, 1, 1, 0, 4);

`ifdef LATCH_MON_HALT_EN
        // Halted: further violations are neither checked nor reported.
        apply(0, 1, 1, 0, 6);
        apply(1, 1, 0, 1, 6);
        check("t6_chk_frozen", chk_cnt,  7);
        check("t6_err_cnt",    err_cnt,  1);
        check("t6_err_code",   err_code, 2);
        check("t6_one_pulse",  ev_count, 1);
        check("t6_busy",       busy,     0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("t6_rst");
        rst = 1'b0;
        apply(0, 0, 0, 0, 4);
`else
        // Opaque latch holding 1; later q drops without an enable.
        apply(1, 1, 1, 1, 6);
        apply(0, 1, 1, 0, 6);
        apply(1, 1, 1, 1, 6);
        apply(1, 0, 1, 1, 6);
        apply(0, 0, 1, 1, 6);
        apply(1, 0, 1, 1, 6);
        check("t4_chk_before", chk_cnt, 12);
        check("t4_err_before", err_cnt, 1);
        apply(1, 0, 1, 0, 6);
        apply(0, 0, 1, 0, 0);
        wait_err("t4_err_pulse", 10);
        check("t4_err_code", err_code, 3);
        apply(0, 0, 1, 0, 4);
        apply(1, 0, 1, 0, 6);
        check("t4_chk_cnt", chk_cnt, 14);
        check("t4_err_cnt", err_cnt, 2);
        check("t4_code_held", err_code, 3);
        check("t4_pulses", ev_count, 2);

        // Disable while settling: no check counted, then re-enable.
        apply(0, 0, 1, 0, 2);
        check("t5_busy_settle", busy, 1);
        chk_en = 1'b0;
        apply(0, 0, 1, 0, 4);
        check("t5_idle_busy", busy, 0);
        check("t5_no_check", chk_cnt, 14);
        chk_en = 1'b1;
        apply(0, 0, 1, 0, 3);
        check("t5_reenable", chk_cnt, 14);

        // Latch in reset with q=1: every check is a violation; counters saturate.
        apply(0, 0, 0, 1, 4);
        for (int i = 0; i < 300; i++) begin
            apply(logic'(i % 2 == 0), 0, 0, 1, 4);
        end
        apply(0, 0, 0, 1, 4);
        check("t5_err_sat", err_cnt, 255);
        check("t5_chk_sat", chk_cnt, 255);
        check("t5_code1",   err_code, 1);
        check("t5_model_sat", m_err, 255);
        apply(1, 0, 0, 1, 6);
        check("t5_err_stays", err_cnt, 255);

        // Reset while a violating check is pending: no pulse, everything cleared.
        apply(0, 0, 0, 1, 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_mid");
        rst = 1'b0;
        apply(0, 0, 0, 0, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
